// File: rtl/smem_result_writer_if.sv
// ----------------------------------------------------------------------------
// smem_result_writer_if
//   Bundles the two streaming sides of the SMEM result writer:
//   - upstream result-RAM handshake (request/permit, 512-bit data, valid,
//     finish, shared stall)
//   - host cache-line write channel (request, address, data, almost-full,
//     write acknowledge)
// Modports:
//   master : the writer block (drives permit, stall and write requests)
//   slave  : the environment (upstream producer plus host memory side)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
interface smem_result_writer_if;
   // upstream handshake
   logic         in_request;
   logic         out_permit;
   logic [511:0] in_data;
   logic         in_valid;
   logic         in_finish;
   logic         stall_out;
   // host write channel
   logic         wr_req_valid;
   logic [41:0]  wr_req_addr;
   logic [511:0] wr_req_data;
   logic         wr_almost_full;
   logic         wr_rsp_valid;

   modport master (
      input  in_request, in_data, in_valid, in_finish,
      input  wr_almost_full, wr_rsp_valid,
      output out_permit, stall_out,
      output wr_req_valid, wr_req_addr, wr_req_data
   );

   modport slave (
      output in_request, in_data, in_valid, in_finish,
      output wr_almost_full, wr_rsp_valid,
      input  out_permit, stall_out,
      input  wr_req_valid, wr_req_addr, wr_req_data
   );
endinterface

// File: rtl/smem_result_writer.sv
// ----------------------------------------------------------------------------
// smem_result_writer
//   Drain stage for the SMEM result RAM. Grants the upstream permit, buffers
//   512-bit result lines in a FIFO (stalling upstream when nearly full) and
//   writes each line to host memory at base + index, one cache line per write.
//   A 'done' pulse follows once every write of the batch has been acknowledged.
//
// Ports:
//   clk            single clock, all logic on posedge
//   reset_n        asynchronous active-low reset
//   start          1-cycle pulse, arms a batch (only honoured in IDLE)
//   wr_base_addr   cache-line base address, captured on start
//   bus            smem_result_writer_if.master (upstream + host write channel)
//   done           1-cycle pulse: batch fully written and acknowledged
//   lines_written  data lines issued in the current batch (header excluded)
//
// Build option:
//   SMEM_RESULT_HEADER_EN  when defined, a header write (addr = base,
//                          data[31:0] = lines_written) is issued after the
//                          data lines, which then start at base + 1.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module smem_result_writer #(
   parameter int FIFO_DEPTH   = 16,
   parameter int AFULL_THRESH = 14,
   parameter int MAX_OUTST    = 32
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        start,
   input  logic [41:0]                 wr_base_addr,
   smem_result_writer_if.master        bus,
   output logic                        done,
   output logic [31:0]                 lines_written
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int OW = $clog2(MAX_OUTST + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ARMED  = 2'd1;
   localparam logic [1:0] ST_STREAM = 2'd2;
   localparam logic [1:0] ST_DRAIN  = 2'd3;

`ifdef SMEM_RESULT_HEADER_EN
   localparam logic [41:0] HDR_OFS = 42'd1;
`else
   localparam logic [41:0] HDR_OFS = 42'd0;
`endif

   logic [1:0]    state_reg, state_next;
   logic [41:0]   base_reg;
   logic [511:0]  fifo_mem [FIFO_DEPTH];
   logic [511:0]  rd_data_reg;
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CW-1:0] fifo_count_reg;
   logic [OW-1:0] outst_reg;
   logic          permit_reg;
   logic          req_valid_reg;
   logic [41:0]   req_addr_reg;
   logic [31:0]   lines_reg;
   logic          done_reg;

   logic          stall;
   logic          push;
   logic          finish_acc;
   logic          can_issue;
   logic          pop;
   logic          issue;
   logic          drained;

`ifdef SMEM_RESULT_HEADER_EN
   logic          hdr_sent_reg;
   logic          hdr_sel_reg;
   logic          hdr_issue;
`endif

   // Stall is decoded from the registered count so upstream sees a clean
   // flop-derived signal; the threshold leaves headroom for in-flight lines.
   assign stall      = (fifo_count_reg >= CW'(AFULL_THRESH));
   assign push       = (state_reg == ST_STREAM) && bus.in_valid && !stall;
   assign finish_acc = (state_reg == ST_STREAM) && bus.in_finish && !stall;
   assign can_issue  = !bus.wr_almost_full && (outst_reg < OW'(MAX_OUTST));
   // A pop requires a line already stored, so read and write never collide
   // on the same FIFO slot.
   assign pop        = (fifo_count_reg != '0) && can_issue;

`ifdef SMEM_RESULT_HEADER_EN
   // Header goes out only after the FIFO is empty, so lines_reg is final.
   assign hdr_issue = (state_reg == ST_DRAIN) && (fifo_count_reg == '0) &&
                      !hdr_sent_reg && can_issue;
   assign issue     = pop || hdr_issue;
   assign drained   = hdr_sent_reg && (fifo_count_reg == '0) &&
                      (outst_reg == '0) && !req_valid_reg;
`else
   assign issue     = pop;
   assign drained   = (fifo_count_reg == '0) && (outst_reg == '0) &&
                      !req_valid_reg;
`endif

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (start)          state_next = ST_ARMED;
         ST_ARMED:  if (bus.in_request) state_next = ST_STREAM;
         ST_STREAM: if (finish_acc)     state_next = ST_DRAIN;
         ST_DRAIN:  if (drained)        state_next = ST_IDLE;
         default:                       state_next = ST_IDLE;
      endcase
   end

   // Line storage and its registered read port; no reset so it maps to RAM.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_reg] <= bus.in_data;
      if (pop)  rd_data_reg          <= fifo_mem[rd_ptr_reg];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= ST_IDLE;
         base_reg       <= '0;
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         fifo_count_reg <= '0;
         outst_reg      <= '0;
         permit_reg     <= 1'b0;
         req_valid_reg  <= 1'b0;
         req_addr_reg   <= '0;
         lines_reg      <= '0;
         done_reg       <= 1'b0;
`ifdef SMEM_RESULT_HEADER_EN
         hdr_sent_reg   <= 1'b0;
         hdr_sel_reg    <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;

         if ((state_reg == ST_IDLE) && start) begin
            base_reg  <= wr_base_addr;
            lines_reg <= '0;
         end else if (pop) begin
            lines_reg <= lines_reg + 32'd1;
         end

         if ((state_reg == ST_ARMED) && bus.in_request)
            permit_reg <= 1'b1;
         else if (finish_acc)
            permit_reg <= 1'b0;

         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;

         case ({push, pop})
            2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
            2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
            default: fifo_count_reg <= fifo_count_reg;
         endcase

         // Saturating decrement: acks for writes issued before a reset
         // must not underflow the counter.
         case ({issue, bus.wr_rsp_valid})
            2'b10:   outst_reg <= outst_reg + 1'b1;
            2'b01:   if (outst_reg != '0) outst_reg <= outst_reg - 1'b1;
            default: outst_reg <= outst_reg;
         endcase

         req_valid_reg <= issue;
         if (pop) begin
            req_addr_reg <= base_reg + HDR_OFS + {10'd0, lines_reg};
         end
`ifdef SMEM_RESULT_HEADER_EN
         else if (hdr_issue) begin
            req_addr_reg <= base_reg;
         end
         hdr_sel_reg <= hdr_issue;
         if ((state_reg == ST_IDLE) && start)
            hdr_sent_reg <= 1'b0;
         else if (hdr_issue)
            hdr_sent_reg <= 1'b1;
`endif

         done_reg <= (state_reg == ST_DRAIN) && drained;
      end
   end

   assign bus.out_permit   = permit_reg;
   assign bus.stall_out    = stall;
   assign bus.wr_req_valid = req_valid_reg;
   assign bus.wr_req_addr  = req_addr_reg;
   // RAM read data is unreset; gating with valid keeps the bus at 0 when idle.
`ifdef SMEM_RESULT_HEADER_EN
   assign bus.wr_req_data  = !req_valid_reg ? '0 :
                             (hdr_sel_reg ? {480'd0, lines_reg} : rd_data_reg);
`else
   assign bus.wr_req_data  = req_valid_reg ? rd_data_reg : '0;
`endif
   assign done             = done_reg;
   assign lines_written    = lines_reg;

endmodule

// File: tb/tb_smem_result_writer.sv
`timescale 1ns/1ps
module tb_smem_result_writer;
   localparam int FD = 16;
   localparam int AT = 14;
   localparam int MO = 4;
`ifdef SMEM_RESULT_HEADER_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [41:0] wr_base_addr = '0;
   logic        done;
   logic [31:0] lines_written;

   smem_result_writer_if bus ();

   smem_result_writer #(.FIFO_DEPTH(FD), .AFULL_THRESH(AT), .MAX_OUTST(MO)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .wr_base_addr  (wr_base_addr),
      .bus           (bus.master),
      .done          (done),
      .lines_written (lines_written)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [41:0]  addr;
      logic [511:0] data;
   } wr_t;

   typedef struct {
      logic [41:0] base;
      int          n;
      int          gap;
      bit          af;
      bit          ackr;
      logic [31:0] exp_lw;
      logic [41:0] exp_first;
   } vec_t;

   int           n_checks = 0;
   int           n_pass   = 0;
   wr_t          wq [$];
   logic [511:0] exp_lines [$];
   int           pending = 0;
   bit           ack_en = 1'b1;
   bit           ack_rand = 1'b0;
   int           ack_credit = 0;
   int           done_cnt = 0;
   int           m_cnt = 0;
   int           m_o = 0;
   logic [41:0]  cur_base = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
   endtask

   task automatic chk_w(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
   endtask

   // One clock: sample after the edge, update the occupancy model, record
   // host writes, then drive the ack for the next edge.
   task automatic tick();
      bit push_now, ack_now, pop_now, hdr_now;
      int pc, po;
      wr_t w;
      push_now = bus.in_valid && bus.out_permit && !bus.stall_out && reset_n;
      ack_now  = bus.wr_rsp_valid;
      @(posedge clk);
      #1;
      if (!reset_n) begin
         m_cnt = 0;
         m_o   = 0;
      end else begin
         hdr_now = bus.wr_req_valid && (HDR == 1) && (bus.wr_req_addr == cur_base);
         pop_now = bus.wr_req_valid && !hdr_now;
         pc = m_cnt;
         po = m_o;
         m_cnt = m_cnt + int'(push_now) - int'(pop_now);
         if (bus.wr_req_valid && !ack_now) m_o++;
         else if (!bus.wr_req_valid && ack_now && m_o > 0) m_o--;
         chk("fifo_count", 64'(dut.fifo_count_reg), 64'(m_cnt));
         chk("outstanding", 64'(dut.outst_reg), 64'(m_o));
         if (push_now && pop_now && ack_now) begin
            chk("same_cycle_count", 64'(dut.fifo_count_reg), 64'(pc));
            chk("same_cycle_outst", 64'(dut.outst_reg), 64'(po));
         end
         if (bus.wr_req_valid) begin
            w.addr = bus.wr_req_addr;
            w.data = bus.wr_req_data;
            wq.push_back(w);
            pending++;
         end
         if (done) done_cnt++;
      end
      if (reset_n && pending > 0 &&
          (ack_credit > 0 || (ack_en && (!ack_rand || $urandom_range(0, 1) == 1)))) begin
         bus.wr_rsp_valid = 1'b1;
         pending--;
         if (ack_credit > 0) ack_credit--;
      end else begin
         bus.wr_rsp_valid = 1'b0;
      end
   endtask

   task automatic do_start(input logic [41:0] base);
      wq.delete();
      exp_lines.delete();
      done_cnt     = 0;
      cur_base     = base;
      start        = 1'b1;
      wr_base_addr = base;
      tick();
      start = 1'b0;
   endtask

   task automatic stream(input int n, input int gap, input bit af_rand, input int af_hold,
                         input bit send_fin, output int stall_at);
      logic [511:0] lines [$];
      logic [511:0] ln;
      int i, guard;
      bit fin, held, acc;
      i = 0; guard = 0; fin = 0; held = 0; stall_at = -1;
      for (int k = 0; k < n; k++) begin
         for (int w = 0; w < 16; w++) ln[w*32 +: 32] = $urandom();
         lines.push_back(ln);
      end
      bus.in_request = 1'b1;
      while ((i < n || (send_fin && !fin)) && guard < 4000) begin
         guard++;
         if (bus.stall_out && stall_at < 0) stall_at = i;
         if (i < n) begin
            bus.in_valid  = held || ($urandom_range(0, 99) >= gap);
            bus.in_data   = lines[i];
            bus.in_finish = 1'b0;
         end else begin
            bus.in_valid  = 1'b0;
            bus.in_finish = 1'b1;
         end
         bus.wr_almost_full = (guard <= af_hold) || (af_rand && $urandom_range(0, 2) == 0);
         acc = bus.out_permit && !bus.stall_out;
         tick();
         if (bus.in_valid) begin
            if (acc) begin
               exp_lines.push_back(lines[i]);
               i++;
               held = 0;
            end else begin
               held = 1;
            end
         end
         if (bus.in_finish && acc) fin = 1;
      end
      chk("stream_complete", 64'(guard < 4000), 64'd1);
      bus.in_valid       = 1'b0;
      bus.in_finish      = 1'b0;
      bus.in_request     = 1'b0;
      bus.wr_almost_full = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int cyc);
      cyc = 0;
      while (done_cnt == 0 && cyc < limit) begin
         tick();
         cyc++;
      end
      chk("done_seen", 64'(done_cnt != 0), 64'd1);
      repeat (3) tick();
   endtask

   task automatic check_batch(input logic [31:0] exp_lw, input logic [41:0] exp_first);
      logic [41:0]  ea;
      logic [511:0] hd;
      int nl;
      nl = exp_lines.size();
      chk("lines_written", 64'(lines_written), 64'(exp_lw));
      chk("done_once", 64'(done_cnt), 64'd1);
      chk("n_writes", 64'(wq.size()), 64'(nl + HDR));
      if (nl > 0 && wq.size() > 0) chk("first_addr", 64'(wq[0].addr), 64'(exp_first));
      for (int i = 0; i < nl && i < wq.size(); i++) begin
         ea = cur_base + 42'(HDR + i);
         chk("wr_addr", 64'(wq[i].addr), 64'(ea));
         chk_w("wr_data", wq[i].data, exp_lines[i]);
      end
      if (HDR == 1 && wq.size() == nl + 1) begin
         hd = '0;
         hd[31:0] = 32'(nl);
         chk("hdr_addr", 64'(wq[nl].addr), 64'(cur_base));
         chk_w("hdr_data", wq[nl].data, hd);
      end
   endtask

   task automatic run_batch(input logic [41:0] base, input int n, input int gap, input bit af,
                            input bit ackr, input logic [31:0] exp_lw, input logic [41:0] exp_first);
      int sa, cyc;
      ack_en   = 1'b1;
      ack_rand = ackr;
      do_start(base);
      stream(n, gap, af, 0, 1'b1, sa);
      wait_done(3000, cyc);
      check_batch(exp_lw, exp_first);
      $display("batch base=0x%0h lines=%0d writes=%0d done_cycles=%0d", base, n, wq.size(), cyc);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt [5];
      int sa, cyc;
      logic [41:0] rb;
      int rn;

      bus.in_request     = 1'b0;
      bus.in_data        = '0;
      bus.in_valid       = 1'b0;
      bus.in_finish      = 1'b0;
      bus.wr_almost_full = 1'b0;
      bus.wr_rsp_valid   = 1'b0;

      vt[0] = '{42'h100,            3,  0, 1'b0, 1'b0, 32'd3,  42'h100 + 42'(HDR)};
      vt[1] = '{42'h3FF_FFFF_FFFE,  4,  0, 1'b0, 1'b0, 32'd4,  42'h3FF_FFFF_FFFE + 42'(HDR)};
      vt[2] = '{42'h2000,           10, 30, 1'b1, 1'b1, 32'd10, 42'h2000 + 42'(HDR)};
      vt[3] = '{42'h5,              1,  0, 1'b0, 1'b1, 32'd1,  42'h5 + 42'(HDR)};
      vt[4] = '{42'h1234,           25, 10, 1'b1, 1'b1, 32'd25, 42'h1234 + 42'(HDR)};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_permit", 64'(bus.out_permit), 64'd0);
      chk("rst_stall", 64'(bus.stall_out), 64'd0);
      chk("rst_wr_valid", 64'(bus.wr_req_valid), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_lines", 64'(lines_written), 64'd0);
      reset_n = 1'b1;
      repeat (2) tick();

      // table-driven batches
      for (int v = 0; v < 5; v++)
         run_batch(vt[v].base, vt[v].n, vt[v].gap, vt[v].af, vt[v].ackr, vt[v].exp_lw, vt[v].exp_first);

      // host almost-full held: FIFO fills to the stall threshold, nothing lost
      ack_en = 1'b1; ack_rand = 1'b0;
      do_start(42'h4000);
      stream(20, 0, 1'b0, 40, 1'b1, sa);
      chk("stall_at_count", 64'(sa), 64'(AT));
      wait_done(3000, cyc);
      check_batch(32'd20, 42'h4000 + 42'(HDR));
      $display("almost_full batch: stall at %0d lines, writes=%0d", sa, wq.size());

      // outstanding limit with acks withheld
      ack_en = 1'b0;
      do_start(42'h8000);
      stream(8, 0, 1'b0, 0, 1'b1, sa);
      repeat (20) tick();
      chk("outst_limit_writes", 64'(wq.size()), 64'(MO));
      for (int k = 1; k <= 3; k++) begin
         ack_credit = 1;
         repeat (6) tick();
         chk("ack_releases_one", 64'(wq.size()), 64'(MO + k));
      end
      ack_en = 1'b1;
      wait_done(3000, cyc);
      check_batch(32'd8, 42'h8000 + 42'(HDR));
      $display("outstanding-limit batch: writes=%0d", wq.size());

      // zero-line batch
      do_start(42'h300);
      stream(0, 0, 1'b0, 0, 1'b1, sa);
      wait_done(50, cyc);
      chk("zero_done_latency_ok", 64'(cyc <= (HDR == 1 ? 8 : 3)), 64'd1);
      check_batch(32'd0, 42'h300);
      $display("zero-line batch: done after %0d cycles, writes=%0d", cyc, wq.size());

      // reset in the middle of a stream with writes outstanding
      ack_en = 1'b0;
      do_start(42'h9000);
      stream(6, 0, 1'b0, 0, 1'b0, sa);
      repeat (4) tick();
      chk("pre_rst_outst", 64'(dut.outst_reg), 64'(MO));
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("async_rst_permit", 64'(bus.out_permit), 64'd0);
      chk("async_rst_wr_valid", 64'(bus.wr_req_valid), 64'd0);
      chk("async_rst_wr_addr", 64'(bus.wr_req_addr), 64'd0);
      chk_w("async_rst_wr_data", bus.wr_req_data, '0);
      chk("async_rst_lines", 64'(lines_written), 64'd0);
      chk("async_rst_done", 64'(done), 64'd0);
      chk("async_rst_outst", 64'(dut.outst_reg), 64'd0);
      repeat (2) tick();
      reset_n = 1'b1;
      ack_en  = 1'b1;
      repeat (8) tick();
      chk("stray_ack_outst", 64'(dut.outst_reg), 64'd0);
      pending = 0;
      run_batch(42'hA000, 5, 0, 1'b0, 1'b0, 32'd5, 42'hA000 + 42'(HDR));

      // randomized batches against the queue model
      for (int r = 0; r < 12; r++) begin
         rb = 42'({$urandom(), $urandom()});
         rn = $urandom_range(0, 30);
         run_batch(rb, rn, $urandom_range(0, 50), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 32'(rn), rb + 42'(HDR));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
